// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_scan_ctrl : two-digit 7-segment scan scheduler with inter-slot blanking
// Revision 1.0
// ----------------------------------------------------------------------------
module seg_scan_ctrl #(
   parameter int SLOT_CYCLES  = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       lock_a,
   input  logic       lock_b,
   input  logic [6:0] seg_a,
   input  logic [6:0] seg_b,
   output logic       mux_sel,
   output logic [6:0] seg_out,
   output logic       dig_a_en,
   output logic       dig_b_en,
   output logic       slot_strb
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SHOW_A   = 3'd1,
      BLANK_AB = 3'd2,
      SHOW_B   = 3'd3,
      BLANK_BA = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam bit               HAS_BLANK  = (BLANK_CYCLES > 0);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mux_q, mux_d;
   logic [6:0]       seg_q, seg_d;
   logic             dga_q, dga_d;
   logic             dgb_q, dgb_d;
   logic             strb_q, strb_d;
   logic             hold;

   // lock_a beats lock_b, so a SHOW_B lock only holds while lock_a is low
   assign hold = ((state_q == SHOW_A) && lock_a) ||
                 ((state_q == SHOW_B) && lock_b && !lock_a);

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:     state_d = (lock_b && !lock_a) ? SHOW_B : SHOW_A;
            SHOW_A:   if (!lock_a && (lock_b || cnt_q == SLOT_LAST))
                         state_d = HAS_BLANK ? BLANK_AB : SHOW_B;
            SHOW_B:   if (lock_a || (!lock_b && cnt_q == SLOT_LAST))
                         state_d = HAS_BLANK ? BLANK_BA : SHOW_A;
            BLANK_AB: if (cnt_q == BLANK_LAST) state_d = SHOW_B;
            BLANK_BA: if (cnt_q == BLANK_LAST) state_d = SHOW_A;
            default:  state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (!en || hold || state_d != state_q)
         cnt_d = '0;
      else if (cnt_q != '1)
         cnt_d = cnt_q + 1'b1;
   end

   // Outputs are decoded from the next state so the registers reflect the current state
   always_comb begin
      mux_d  = mux_q;
      seg_d  = 7'h00;
      dga_d  = 1'b0;
      dgb_d  = 1'b0;
      strb_d = 1'b0;
      case (state_d)
         SHOW_A: begin
            mux_d  = 1'b1;
            seg_d  = seg_a;
            dga_d  = 1'b1;
            strb_d = (state_q != SHOW_A);
         end
         SHOW_B: begin
            mux_d  = 1'b0;
            seg_d  = seg_b;
            dgb_d  = 1'b1;
            strb_d = (state_q != SHOW_B);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mux_q   <= 1'b1;
         seg_q   <= 7'h00;
         dga_q   <= 1'b0;
         dgb_q   <= 1'b0;
         strb_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mux_q   <= mux_d;
         seg_q   <= seg_d;
         dga_q   <= dga_d;
         dgb_q   <= dgb_d;
         strb_q  <= strb_d;
      end
   end

   assign mux_sel   = mux_q;
   assign seg_out   = seg_q;
   assign dig_a_en  = dga_q;
   assign dig_b_en  = dgb_q;
   assign slot_strb = strb_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seg_scan_ctrl : directed self-checking bench, SLOT=4 with BLANK=2 and BLANK=0
// Revision 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, en, lock_a, lock_b;
   logic [6:0] seg_a, seg_b;
   logic       mux_sel, dig_a_en, dig_b_en, slot_strb;
   logic [6:0] seg_out;
   logic       mux0, dga0, dgb0, strb0;
   logic [6:0] seg0;
   int         n_pass = 0;
   int         n_total = 0;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.SLOT_CYCLES(4), .BLANK_CYCLES(2), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .lock_a(lock_a), .lock_b(lock_b),
      .seg_a(seg_a), .seg_b(seg_b), .mux_sel(mux_sel), .seg_out(seg_out),
      .dig_a_en(dig_a_en), .dig_b_en(dig_b_en), .slot_strb(slot_strb));

   seg_scan_ctrl #(.SLOT_CYCLES(4), .BLANK_CYCLES(0), .CNT_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .lock_a(lock_a), .lock_b(lock_b),
      .seg_a(seg_a), .seg_b(seg_b), .mux_sel(mux0), .seg_out(seg0),
      .dig_a_en(dga0), .dig_b_en(dgb0), .slot_strb(strb0));

   // {mux_sel, seg_out, dig_a_en, dig_b_en, slot_strb}
   function automatic logic [10:0] vec(input logic m, input logic [6:0] s,
                                       input logic a, input logic b, input logic st);
      return {m, s, a, b, st};
   endfunction

   function automatic logic [10:0] got1();
      return {mux_sel, seg_out, dig_a_en, dig_b_en, slot_strb};
   endfunction

   function automatic logic [10:0] got0();
      return {mux0, seg0, dga0, dgb0, strb0};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      en = 1'b0; lock_a = 1'b0; lock_b = 1'b0;
      step();
   endtask

   task automatic test_reset();
      logic [10:0] e;
      rst_n = 1'b0; en = 1'b0; lock_a = 1'b0; lock_b = 1'b0;
      seg_a = 7'h3F; seg_b = 7'h06;
      #12;
      e = vec(1'b1, 7'h00, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (got1() !== e) $display("FAIL reset: got %h expected %h", got1(), e);
      else n_pass++;
      n_total++;
      if (got0() !== e) $display("FAIL reset_b0: got %h expected %h", got0(), e);
      else n_pass++;
      rst_n = 1'b1;
   endtask

   // 12-cycle period with blanks; 8-cycle back-to-back period without
   task automatic test_scan();
      logic [10:0] e;
      int p, q;
      en = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         step();
         p = (k - 1) % 12;
         q = (k - 1) % 8;
         if (p < 4)       e = vec(1'b1, 7'h3F, 1'b1, 1'b0, p == 0);
         else if (p < 6)  e = vec(1'b1, 7'h00, 1'b0, 1'b0, 1'b0);
         else if (p < 10) e = vec(1'b0, 7'h06, 1'b0, 1'b1, p == 6);
         else             e = vec(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
         n_total++;
         if (got1() !== e) $display("FAIL scan k=%0d: got %h expected %h", k, got1(), e);
         else n_pass++;
         if (q < 4) e = vec(1'b1, 7'h3F, 1'b1, 1'b0, q == 0);
         else       e = vec(1'b0, 7'h06, 1'b0, 1'b1, q == 4);
         n_total++;
         if (got0() !== e) $display("FAIL scan_noblank k=%0d: got %h expected %h", k, got0(), e);
         else n_pass++;
      end
   endtask

   task automatic test_lock_a();
      logic [10:0] e;
      go_idle();
      en = 1'b1; lock_a = 1'b1;
      step();
      e = vec(1'b1, 7'h3F, 1'b1, 1'b0, 1'b1);
      n_total++;
      if (got1() !== e) $display("FAIL lock_a_entry: got %h expected %h", got1(), e);
      else n_pass++;
      e = vec(1'b1, 7'h3F, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 50; k++) begin
         step();
         n_total++;
         if (got1() !== e) $display("FAIL lock_a_hold k=%0d: got %h expected %h", k, got1(), e);
         else n_pass++;
      end
      lock_a = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         n_total++;
         if (got1() !== e) $display("FAIL lock_a_release k=%0d: got %h expected %h", k, got1(), e);
         else n_pass++;
      end
      step();
      e = vec(1'b1, 7'h00, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (got1() !== e) $display("FAIL lock_a_blank: got %h expected %h", got1(), e);
      else n_pass++;
   endtask

   task automatic test_lock_b();
      logic [10:0] e;
      go_idle();
      en = 1'b1;
      step();
      lock_b = 1'b1;
      step();
      e = vec(1'b1, 7'h00, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (got1() !== e) $display("FAIL lock_b_blank0: got %h expected %h", got1(), e);
      else n_pass++;
      step();
      n_total++;
      if (got1() !== e) $display("FAIL lock_b_blank1: got %h expected %h", got1(), e);
      else n_pass++;
      step();
      e = vec(1'b0, 7'h06, 1'b0, 1'b1, 1'b1);
      n_total++;
      if (got1() !== e) $display("FAIL lock_b_entry: got %h expected %h", got1(), e);
      else n_pass++;
      e = vec(1'b0, 7'h06, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 10; k++) begin
         step();
         n_total++;
         if (got1() !== e) $display("FAIL lock_b_hold k=%0d: got %h expected %h", k, got1(), e);
         else n_pass++;
      end
   endtask

   task automatic test_both_locks();
      logic [10:0] e;
      go_idle();
      en = 1'b1; lock_a = 1'b1; lock_b = 1'b1;
      step();
      e = vec(1'b1, 7'h3F, 1'b1, 1'b0, 1'b1);
      n_total++;
      if (got1() !== e) $display("FAIL both_locks_entry: got %h expected %h", got1(), e);
      else n_pass++;
      e = vec(1'b1, 7'h3F, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         step();
         n_total++;
         if (got1() !== e) $display("FAIL both_locks_hold k=%0d: got %h expected %h", k, got1(), e);
         else n_pass++;
      end
   endtask

   task automatic test_en_drop();
      logic [10:0] e;
      go_idle();
      en = 1'b1;
      step();
      for (int k = 0; k < 6; k++) step();
      e = vec(1'b0, 7'h06, 1'b0, 1'b1, 1'b1);
      n_total++;
      if (got1() !== e) $display("FAIL en_drop_in_b: got %h expected %h", got1(), e);
      else n_pass++;
      step();
      seg_b = 7'h5B;
      step();
      e = vec(1'b0, 7'h5B, 1'b0, 1'b1, 1'b0);
      n_total++;
      if (got1() !== e) $display("FAIL seg_b_latency: got %h expected %h", got1(), e);
      else n_pass++;
      en = 1'b0;
      step();
      e = vec(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (got1() !== e) $display("FAIL en_drop_dark: got %h expected %h", got1(), e);
      else n_pass++;
      en = 1'b1;
      step();
      e = vec(1'b1, 7'h3F, 1'b1, 1'b0, 1'b1);
      n_total++;
      if (got1() !== e) $display("FAIL en_reraise: got %h expected %h", got1(), e);
      else n_pass++;
      seg_b = 7'h06;
   endtask

   task automatic test_async_reset();
      logic [10:0] e;
      go_idle();
      en = 1'b1;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      e = vec(1'b1, 7'h00, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (got1() !== e) $display("FAIL async_reset: got %h expected %h", got1(), e);
      else n_pass++;
      #2;
      rst_n = 1'b1;
      step();
      e = vec(1'b1, 7'h3F, 1'b1, 1'b0, 1'b1);
      n_total++;
      if (got1() !== e) $display("FAIL after_reset: got %h expected %h", got1(), e);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_scan();
      test_lock_a();
      test_lock_b();
      test_both_locks();
      test_en_drop();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
